// File: rtl/ym3438_pkg.sv
// Shared constants and slot decoding for the YM3438 slot scheduler.
// A slot maps to a channel (slot mod 6) and an operator (op1, op3, op2, op4 order).
package ym3438_pkg;

  localparam int SLOT_COUNT = 24;
  localparam int CH_COUNT   = 6;

  // Operator index per group of six slots; entry 0 is the LSB pair.
  localparam logic [3:0][1:0] OP_ORDER = {2'd3, 2'd1, 2'd2, 2'd0};

  typedef struct packed {
    logic [2:0] ch;
    logic [1:0] op;
  } slot_map_t;

  function automatic slot_map_t slot_decode(input logic [4:0] s);
    slot_map_t  m;
    logic [1:0] grp;
    logic [4:0] base;
    if (s >= 5'(3 * CH_COUNT))
      grp = 2'd3;
    else if (s >= 5'(2 * CH_COUNT))
      grp = 2'd2;
    else if (s >= 5'(CH_COUNT))
      grp = 2'd1;
    else
      grp = 2'd0;
    base = 5'(grp) * 5'(CH_COUNT);
    m.ch = 3'(s - base);
    m.op = OP_ORDER[grp];
    return m;
  endfunction

endpackage

// File: rtl/ym3438_rise_det.sv
// Rising-edge detector: registered history of d, pulse while d=1 and the previous sample was 0.
// The reset value of the history lets a caller suppress a pulse for a level already high at release.
module ym3438_rise_det #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (reset)
      d_q <= RESET_VAL;
    else
      d_q <= d;
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/ym3438_slot_scheduler.sv
// Slot sequencer: steps through 24 operator slots on each c1 rising edge, emitting slot,
// sample and timer B strobes; reset_fsm realigns to slot 0 and marks the sequencer locked.
module ym3438_slot_scheduler
  import ym3438_pkg::*;
#(
  parameter int TIMERB_DIV = 16
) (
  input  logic       MCLK,
  input  logic       RESET,
  input  logic       c1,
  input  logic       c2,
  input  logic       reset_fsm,
  output logic [4:0] slot,
  output logic [2:0] ch,
  output logic [1:0] op,
  output logic       slot_stb,
  output logic       sample_stb,
  output logic       timer_b_tick,
  output logic       locked,
  output logic       phase_err
);

  localparam int CNT_W = (TIMERB_DIV > 1) ? $clog2(TIMERB_DIV) : 1;

  logic             advance;
  logic             wrap;
  logic [4:0]       slot_next;
  slot_map_t        map_next;
  logic [CNT_W-1:0] sample_cnt;

  // History resets to 1 so a c1 already high when RESET drops is not taken as an edge.
  ym3438_rise_det #(
    .RESET_VAL(1'b1)
  ) u_c1_rise (
    .clk  (MCLK),
    .reset(RESET),
    .d    (c1),
    .pulse(advance)
  );

  always_comb begin
    wrap      = (slot == 5'(SLOT_COUNT - 1));
    slot_next = wrap ? 5'd0 : slot + 5'd1;
    map_next  = slot_decode(slot_next);
  end

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      slot         <= '0;
      ch           <= '0;
      op           <= '0;
      slot_stb     <= 1'b0;
      sample_stb   <= 1'b0;
      timer_b_tick <= 1'b0;
      locked       <= 1'b0;
      phase_err    <= 1'b0;
      sample_cnt   <= '0;
    end else begin
      slot_stb     <= 1'b0;
      sample_stb   <= 1'b0;
      timer_b_tick <= 1'b0;
      if (c1 && c2)
        phase_err <= 1'b1;
      if (advance) begin
        slot_stb <= 1'b1;
        if (reset_fsm) begin
          slot       <= '0;
          ch         <= '0;
          op         <= '0;
          sample_cnt <= '0;
          locked     <= 1'b1;
        end else begin
          slot <= slot_next;
          ch   <= map_next.ch;
          op   <= map_next.op;
          // Timer B fires on the sample that brings the divider back around to zero.
          if (wrap) begin
            sample_stb <= 1'b1;
            sample_cnt <= sample_cnt + 1'b1;
            if (sample_cnt == CNT_W'(TIMERB_DIV - 1))
              timer_b_tick <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ym3438_slot_scheduler.sv
// Directed bench for ym3438_slot_scheduler: a vector table for basic stepping and
// hand-written sequences for sweep, realignment, timer B, reset and phase-error cases.
module tb_ym3438_slot_scheduler;

  logic       MCLK;
  logic       RESET;
  logic       c1;
  logic       c2;
  logic       reset_fsm;
  logic [4:0] slot;
  logic [2:0] ch;
  logic [1:0] op;
  logic       slot_stb;
  logic       sample_stb;
  logic       timer_b_tick;
  logic       locked;
  logic       phase_err;

  int checks = 0;
  int errors = 0;
  int op_tab[4] = '{0, 2, 1, 3};

  typedef struct {
    logic        c1;
    logic        c2;
    logic        rf;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[12];

  ym3438_slot_scheduler #(
    .TIMERB_DIV(16)
  ) dut (
    .MCLK        (MCLK),
    .RESET       (RESET),
    .c1          (c1),
    .c2          (c2),
    .reset_fsm   (reset_fsm),
    .slot        (slot),
    .ch          (ch),
    .op          (op),
    .slot_stb    (slot_stb),
    .sample_stb  (sample_stb),
    .timer_b_tick(timer_b_tick),
    .locked      (locked),
    .phase_err   (phase_err)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  // Output bundle order: slot, ch, op, slot_stb, sample_stb, timer_b_tick, locked, phase_err.
  function automatic logic [14:0] bundle(input int s, input int c, input int o, input int ss,
                                         input int sp, input int tk, input int lk, input int pe);
    return {5'(s), 3'(c), 2'(o), 1'(ss), 1'(sp), 1'(tk), 1'(lk), 1'(pe)};
  endfunction

  function automatic logic [14:0] dut_bundle();
    return {slot, ch, op, slot_stb, sample_stb, timer_b_tick, locked, phase_err};
  endfunction

  task automatic applyStimulus(input logic c1v, input logic c2v, input logic rfv, input logic rstv);
    @(negedge MCLK);
    c1        = c1v;
    c2        = c2v;
    reset_fsm = rfv;
    RESET     = rstv;
    @(posedge MCLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic doReset(input logic c1v);
    applyStimulus(c1v, 1'b0, 1'b0, 1'b1);
    applyStimulus(c1v, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int es;
    int cnt;
    int ticks;

    RESET = 1'b1; c1 = 1'b0; c2 = 1'b0; reset_fsm = 1'b0;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, bundle(0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, bundle(1, 1, 0, 1, 0, 0, 0, 0)};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, bundle(1, 1, 0, 0, 0, 0, 0, 0)};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, bundle(1, 1, 0, 0, 0, 0, 0, 0)};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, bundle(2, 2, 0, 1, 0, 0, 0, 0)};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, bundle(2, 2, 0, 0, 0, 0, 0, 0)};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, bundle(0, 0, 0, 1, 0, 0, 1, 0)};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, bundle(0, 0, 0, 0, 0, 0, 1, 0)};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, bundle(0, 0, 0, 1, 0, 0, 1, 0)};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, bundle(0, 0, 0, 0, 0, 0, 1, 0)};
    vecs[10] = '{1'b1, 1'b0, 1'b0, bundle(1, 1, 0, 1, 0, 0, 1, 0)};
    vecs[11] = '{1'b0, 1'b1, 1'b0, bundle(1, 1, 0, 0, 0, 0, 1, 0)};

    doReset(1'b0);
    checkOutput("reset_state", dut_bundle(), bundle(0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].c1, vecs[i].c2, vecs[i].rf, 1'b0);
      checkOutput($sformatf("vec%0d", i), dut_bundle(), vecs[i].exp);
    end

    // Full sweep of 24 slots with 1-high/5-low c1 pulses.
    doReset(1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 24; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      es = (k + 1) % 24;
      checkOutput($sformatf("sweep_adv%0d", k), dut_bundle(),
                  bundle(es, es % 6, op_tab[es / 6], 1, (k == 23) ? 1 : 0, 0, 0, 0));
      if (es == 13)
        checkOutput("slot13_ch_op", {27'd0, ch, op}, {27'd0, 3'd1, 2'd1});
      repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("sweep_hold%0d", k), dut_bundle(),
                  bundle(es, es % 6, op_tab[es / 6], 0, 0, 0, 0, 0));
    end

    // Realignment at slot 10, then one full rotation ending in sample_stb.
    doReset(1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (10) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("pre_lock_slot", {27'd0, slot}, 32'd10);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("lock_adv", dut_bundle(), bundle(0, 0, 0, 1, 0, 0, 1, 0));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 24; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      es = (k + 1) % 24;
      checkOutput($sformatf("post_lock_adv%0d", k), dut_bundle(),
                  bundle(es, es % 6, op_tab[es / 6], 1, (k == 23) ? 1 : 0, 0, 1, 0));
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Timer B: relock clears the divider, then 16 samples give one tick on the 16th.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    ticks = 0;
    for (int n = 1; n <= 384; n++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      es = n % 24;
      if (timer_b_tick) ticks++;
      checkOutput($sformatf("timerb_adv%0d", n), dut_bundle(),
                  bundle(es, es % 6, op_tab[es / 6], 1, (es == 0) ? 1 : 0, (n == 384) ? 1 : 0, 1, 0));
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      if (timer_b_tick) ticks++;
    end
    checkOutput("timerb_tick_count", ticks, 32'd1);

    // c1 already high at reset release must not advance.
    doReset(1'b1);
    cnt = 0;
    repeat (10) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      if (slot_stb) cnt++;
    end
    checkOutput("held_c1_stb_count", cnt, 32'd0);
    checkOutput("held_c1_slot", {27'd0, slot}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("held_c1_first_edge", dut_bundle(), bundle(1, 1, 0, 1, 0, 0, 0, 0));

    // Phase error is sticky until RESET.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("phase_err_set", {31'd0, phase_err}, 32'd1);
    cnt = 0;
    repeat (100) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      if (!phase_err) cnt++;
    end
    checkOutput("phase_err_sticky_drops", cnt, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("phase_err_reset", dut_bundle(), bundle(0, 0, 0, 0, 0, 0, 0, 0));

    // RESET wins over a simultaneous advance and reset_fsm at slot 17.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (17) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("pre_reset_slot", {27'd0, slot}, 32'd17);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("reset_priority", dut_bundle(), bundle(0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_priority_after", dut_bundle(), bundle(0, 0, 0, 0, 0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ym3438_slot_scheduler.md
YM3438_SLOT_SCHEDULER -- requirements
Module: ym3438_slot_scheduler

Interface
REQ-001 SHALL have parameter TIMERB_DIV, default 16, samples per timer_b_tick (power of two, 2..256).
REQ-002 SHALL have port MCLK  input  1  master clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have port c1  input  1  prescaler phase-1 clock level; rising edge advances the slot.
REQ-005 SHALL have port c2  input  1  prescaler phase-2 clock level; used only for phase checking.
REQ-006 SHALL have port reset_fsm  input  1  prescaler FSM-reset request; forces slot alignment.
REQ-007 SHALL have port slot  output  5  current slot number, 0..23.
REQ-008 SHALL have port ch  output  3  channel index, 0..5.
REQ-009 SHALL have port op  output  2  operator index, 0..3.
REQ-010 SHALL have port slot_stb  output  1  one-MCLK pulse per slot advance.
REQ-011 SHALL have port sample_stb  output  1  one-MCLK pulse on wrap from slot 23 to slot 0.
REQ-012 SHALL have port timer_b_tick  output  1  one-MCLK pulse every TIMERB_DIV sample_stb pulses.
REQ-013 SHALL have port locked  output  1  high once aligned by reset_fsm.
REQ-014 SHALL have port phase_err  output  1  sticky flag for c1 and c2 high together.

Function
REQ-015 Advance event: c1 sampled 1 at an MCLK edge and 0 at the previous edge; slot, ch, op and the strobes update at that same edge.
REQ-016 On an advance with reset_fsm=0: slot = (slot==23) ? 0 : slot+1; slot_stb=1 for exactly one cycle.
REQ-017 On an advance with reset_fsm=1: slot=0, slot_stb=1, sample_stb=0, timer_b divider cleared, locked=1.
REQ-018 ch SHALL equal slot mod 6; op SHALL be {0,2,1,3}[slot/6] (slot order op1, op3, op2, op4).
REQ-019 sample_stb=1 only on the advance where slot goes 23->0 with reset_fsm=0; coincident with slot_stb.
REQ-020 A log2(TIMERB_DIV)-bit sample counter SHALL increment on each sample_stb; timer_b_tick pulses with the sample_stb on which it wraps to 0 (the TIMERB_DIV-th sample).
REQ-021 No advance event: slot, ch, op, divider hold; all strobes 0.
REQ-022 phase_err SHALL be set at any edge where c1=1 and c2=1 are both sampled, and SHALL be cleared only by RESET.
REQ-023 c1 held high continuously SHALL produce exactly one advance.
REQ-024 reset_fsm held over several advances SHALL keep slot at 0 and emit slot_stb on each advance, with no sample_stb.

Reset
REQ-025 RESET=1 at an edge: slot=0, ch=0, op=0, all strobes 0, divider 0, locked=0, phase_err=0.
REQ-026 RESET SHALL load the registered c1 history with 1, so a c1 already high at release produces no advance.
REQ-027 RESET SHALL take priority over every other input, including an advance and reset_fsm in the same cycle.

Structure
REQ-028 Shared package ym3438_pkg SHALL hold SLOT_COUNT=24, CH_COUNT=6, and the operator-order table.
REQ-029 Rising-edge detection SHALL be a sub-module ym3438_rise_det (d in, registered history, 1-cycle pulse out, reset value of history parameterised).
REQ-030 All outputs SHALL be registered; there is no combinational path from input to output.

Verification
REQ-031 Reset, then 24 c1 pulses (each 1 high, 5 low MCLK cycles) -> slot 1..23,0; sample_stb only on the 24th; ch/op match REQ-018 (slot 13 -> ch 1, op 1).
REQ-032 reset_fsm high at the advance where slot 10 would become 11 -> slot 0, locked 1, no sample_stb; the next 24 advances end with sample_stb.
REQ-033 TIMERB_DIV=16, 16x24 advances after lock -> exactly one timer_b_tick, coincident with the 16th sample_stb.
REQ-034 c1 held 1 at RESET release for 10 cycles -> no slot_stb; the first 0->1 transition afterwards -> slot 1.
REQ-035 c1=c2=1 for one cycle -> phase_err 1 and it stays 1 through 100 cycles; RESET -> 0.
REQ-036 RESET asserted mid-count at slot 17 with a simultaneous advance -> next cycle slot 0, locked 0, strobes 0.
